// File: rtl/sram_port0_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM macro (port 0).
// After reset the whole array is optionally zero-filled, then each granted access
// walks IDLE -> CMD -> WAIT -> RESP and returns a one-cycle ack to its requester.
// Every macro-side pin and every requester output comes straight from a flop.
module sram_port0_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 4,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst_n,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_sel,
    input  logic [ADDR_WIDTH-1:0] a_adr,
    input  logic [DATA_WIDTH-1:0] a_dat_w,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_dat_r,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_sel,
    input  logic [ADDR_WIDTH-1:0] b_adr,
    input  logic [DATA_WIDTH-1:0] b_dat_w,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_dat_r,

    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  init_done
);

    typedef enum logic [2:0] {StInit, StIdle, StCmd, StWait, StResp} state_e;

    localparam state_e ResetState = INIT_EN ? StInit : StIdle;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    last_b_q;   // 1: b was granted most recently
    logic                    grant_b_q;  // grantee of the access in flight
    logic                    we_q;       // in-flight access is a write

    logic                    any_req;
    logic                    pick_b;
    logic                    sel_we;
    logic [NUM_WMASKS-1:0]   sel_sel;
    logic [ADDR_WIDTH-1:0]   sel_adr;
    logic [DATA_WIDTH-1:0]   sel_dat;

    // Round-robin choice: on a tie grant whoever was not granted last.
    always_comb begin
        any_req = a_req | b_req;
        pick_b  = b_req & (~a_req | ~last_b_q);
        sel_we  = pick_b ? b_we    : a_we;
        sel_sel = pick_b ? b_sel   : a_sel;
        sel_adr = pick_b ? b_adr   : a_adr;
        sel_dat = pick_b ? b_dat_w : a_dat_w;
    end

    // Single FSM: state, init counter, grant bookkeeping and all registered outputs.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ResetState;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            we_q      <= 1'b0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            addr0     <= '0;
            din0      <= '0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_dat_r   <= '0;
            b_dat_r   <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    csb0   <= 1'b0;
                    web0   <= 1'b0;
                    wmask0 <= '1;
                    din0   <= '0;
                    addr0  <= cnt_q;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q   <= StIdle;
                        init_done <= 1'b1;
                    end
                end
                StIdle: begin
                    // Covers the INIT_EN=0 case, where IDLE is the first state.
                    init_done <= 1'b1;
                    csb0      <= 1'b1;
                    web0      <= 1'b1;
                    if (init_done && any_req) begin
                        grant_b_q <= pick_b;
                        last_b_q  <= pick_b;
                        we_q      <= sel_we;
                        csb0      <= 1'b0;
                        web0      <= ~sel_we;
                        wmask0    <= sel_we ? sel_sel : '1;
                        addr0     <= sel_adr;
                        din0      <= sel_dat;
                        state_q   <= StCmd;
                    end
                end
                StCmd: begin
                    // Macro samples the command pins at this edge.
                    csb0    <= 1'b1;
                    web0    <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (grant_b_q) begin
                        b_ack <= 1'b1;
                        if (!we_q) b_dat_r <= dout0;
                    end else begin
                        a_ack <= 1'b1;
                        if (!we_q) a_dat_r <= dout0;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
